// File: rtl/compair_fee_pkg.sv
// ---------------------------------------------------------------------------
// compair_fee_pkg
// Shared definitions for the ComPair FEE layer readout logic.
//   NLAYERS_DEF  : default number of detector layers
//   layer_idx_t  : index type wide enough for NLAYERS_DEF layers
//   arb_state_t  : readout arbiter FSM states
// ---------------------------------------------------------------------------
package compair_fee_pkg;

    localparam int NLAYERS_DEF = 20;

    typedef logic [4:0] layer_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        READ,
        RELEASE
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. It searches upward from ptr+1 and
// wraps at N. The search returns the first set bit of req, so the entry at
// ptr itself gets the lowest priority.
//   req   in  N        : request vector
//   ptr   in  clog2(N) : index of the last grant
//   valid out 1        : at least one request is set
//   idx   out clog2(N) : selected index (0 when valid=0)
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int N = 20
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 valid,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    int cand;

    // Walk the offsets from farthest to nearest. The last hit wins, so the
    // nearest set bit after ptr is the one left in idx.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int off = N; off >= 1; off--) begin
            cand = (int'(ptr) + off) % N;
            if (req[cand]) begin
                valid = 1'b1;
                idx   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/layer_irq_arbiter.sv
// ---------------------------------------------------------------------------
// layer_irq_arbiter
// Round-robin arbiter between the per-layer interrupt pins and the shared
// layer readout engine.
// The block synchronises the active-low interrupts and masks them with
// layer_enable. It grants one layer at a time: it raises that layer's hold,
// waits HOLD_SETUP cycles, then requests a readout. A watchdog aborts a read
// that never completes.
//   sysclk           in  : system clock
//   warm_resn        in  : asynchronous active-low reset
//   layer_interruptn in  : raw asynchronous interrupts, active-low
//   layer_enable     in  : per-layer eligibility mask
//   layer_hold       out : one-hot hold to the granted layer
//   rd_req           out : readout request to the engine
//   rd_layer         out : granted layer index (valid while rd_req)
//   rd_done          in  : one-cycle pulse, readout finished
//   pending          out : synchronised, masked interrupt status
//   timeout_pulse    out : one-cycle pulse on watchdog abort
//   timeout_layer    out : layer of the most recent timeout
// ---------------------------------------------------------------------------
module layer_irq_arbiter
    import compair_fee_pkg::*;
#(
    parameter int NLAYERS     = NLAYERS_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_SETUP  = 4,
    parameter int TIMEOUT     = 65535
) (
    input  logic                       sysclk,
    input  logic                       warm_resn,
    input  logic [NLAYERS-1:0]         layer_interruptn,
    input  logic [NLAYERS-1:0]         layer_enable,
    output logic [NLAYERS-1:0]         layer_hold,
    output logic                       rd_req,
    output logic [$clog2(NLAYERS)-1:0] rd_layer,
    input  logic                       rd_done,
    output logic [NLAYERS-1:0]         pending,
    output logic                       timeout_pulse,
    output logic [$clog2(NLAYERS)-1:0] timeout_layer
);

    localparam int IW = $clog2(NLAYERS);
    localparam int CW = (HOLD_SETUP > 1) ? $clog2(HOLD_SETUP) : 1;
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    // ---------------- interrupt synchronisers ----------------
    // The synchronisers reset to 1 (idle), so nothing is pending out of reset.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            logic [NLAYERS-1:0] q;
            if (gi == 0) begin : g_first
                always_ff @(posedge sysclk or negedge warm_resn) begin
                    if (!warm_resn) q <= '1;
                    else            q <= layer_interruptn;
                end
            end else begin : g_rest
                always_ff @(posedge sysclk or negedge warm_resn) begin
                    if (!warm_resn) q <= '1;
                    else            q <= g_sync[gi-1].q;
                end
            end
        end
    endgenerate

    assign pending = ~g_sync[SYNC_STAGES-1].q & layer_enable;

    // ---------------- round-robin pick ----------------
    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] ptr_q, ptr_d;

    rr_pick #(.N(NLAYERS)) u_pick (
        .req   (pending),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // ---------------- arbiter FSM ----------------
    arb_state_t         state_q, state_d;
    logic [IW-1:0]      layer_q, layer_d;
    logic [NLAYERS-1:0] hold_q, hold_d;
    logic               req_q, req_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [15:0]        wd_q, wd_d;
    logic               to_pulse_q, to_pulse_d;
    logic [IW-1:0]      to_layer_q, to_layer_d;

    always_ff @(posedge sysclk or negedge warm_resn) begin
        if (!warm_resn) begin
            state_q    <= IDLE;
            ptr_q      <= IW'(NLAYERS - 1);   // layer 0 is served first
            layer_q    <= '0;
            hold_q     <= '0;
            req_q      <= 1'b0;
            cnt_q      <= '0;
            wd_q       <= '0;
            to_pulse_q <= 1'b0;
            to_layer_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            layer_q    <= layer_d;
            hold_q     <= hold_d;
            req_q      <= req_d;
            cnt_q      <= cnt_d;
            wd_q       <= wd_d;
            to_pulse_q <= to_pulse_d;
            to_layer_q <= to_layer_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        layer_d    = layer_q;
        hold_d     = hold_q;
        req_d      = req_q;
        cnt_d      = cnt_q;
        wd_d       = wd_q;
        to_pulse_d = 1'b0;
        to_layer_d = to_layer_q;
        unique case (state_q)
            IDLE: begin
                // The grant becomes the new pointer, so this layer drops to
                // the lowest priority at the next arbitration.
                if (pick_valid) begin
                    layer_d          = pick_idx;
                    ptr_d            = pick_idx;
                    hold_d           = '0;
                    hold_d[pick_idx] = 1'b1;
                    cnt_d            = CW'(HOLD_SETUP - 1);
                    state_d          = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    req_d   = 1'b1;
                    wd_d    = '0;
                    state_d = READ;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            READ: begin
                // If done and the watchdog expire in the same cycle, done
                // wins and no timeout is reported.
                if (rd_done) begin
                    req_d   = 1'b0;
                    hold_d  = '0;
                    state_d = RELEASE;
                end else if (wd_q == WD_LAST) begin
                    req_d      = 1'b0;
                    hold_d     = '0;
                    to_pulse_d = 1'b1;
                    to_layer_d = layer_q;
                    state_d    = RELEASE;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
            end
            RELEASE: begin
                // This spare cycle keeps hold low for at least two cycles
                // between grants.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign layer_hold    = hold_q;
    assign rd_req        = req_q;
    assign rd_layer      = layer_q;
    assign timeout_pulse = to_pulse_q;
    assign timeout_layer = to_layer_q;

endmodule

// File: tb/tb_layer_irq_arbiter.sv
// ---------------------------------------------------------------------------
// tb_layer_irq_arbiter
// Directed bench for layer_irq_arbiter (NLAYERS=20, SYNC_STAGES=2,
// HOLD_SETUP=4, TIMEOUT=16). Expected grant order is queued when interrupts
// are driven and popped as each grant appears.
// ---------------------------------------------------------------------------
module tb_layer_irq_arbiter;

    localparam int NL  = 20;
    localparam int HS  = 4;
    localparam int TO  = 16;

    logic          clk = 1'b0;
    logic          warm_resn;
    logic [NL-1:0] layer_interruptn;
    logic [NL-1:0] layer_enable;
    logic [NL-1:0] layer_hold;
    logic          rd_req;
    logic [4:0]    rd_layer;
    logic          rd_done;
    logic [NL-1:0] pending;
    logic          timeout_pulse;
    logic [4:0]    timeout_layer;

    int tests = 0;
    int fails = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    layer_irq_arbiter #(
        .NLAYERS     (NL),
        .SYNC_STAGES (2),
        .HOLD_SETUP  (HS),
        .TIMEOUT     (TO)
    ) dut (
        .sysclk           (clk),
        .warm_resn        (warm_resn),
        .layer_interruptn (layer_interruptn),
        .layer_enable     (layer_enable),
        .layer_hold       (layer_hold),
        .rd_req           (rd_req),
        .rd_layer         (rd_layer),
        .rd_done          (rd_done),
        .pending          (pending),
        .timeout_pulse    (timeout_pulse),
        .timeout_layer    (timeout_layer)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Wait for the next hold, pop the expected layer, and verify the one-hot
    // hold, the HOLD_SETUP delay to rd_req, and rd_layer. Returns at the rd_req edge.
    task automatic grant_check(output int hw);
        int            exp;
        int            n;
        logic [NL-1:0] oh;
        hw = 0;
        while (layer_hold == '0 && hw < 60) begin
            tick();
            hw++;
        end
        check("hold_seen", {31'd0, layer_hold != '0}, 1);
        check("sb_nonempty", {31'd0, exp_q.size() != 0}, 1);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 0;
        oh = '0;
        oh[exp] = 1'b1;
        check("hold_onehot", layer_hold, oh);
        check("req_before_setup", rd_req, 0);
        n = 0;
        while (!rd_req && n < 30) begin
            tick();
            n++;
        end
        check("hold_to_req", n, HS);
        check("rd_layer", rd_layer, exp);
        check("hold_in_read", layer_hold, oh);
        $display("[TB] grant layer %0d: hold after %0d cycles, req after %0d more", exp, hw, n);
    endtask

    task automatic finish_read(input int delay);
        repeat (delay) tick();
        check("req_held", rd_req, 1);
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        check("req_drop", rd_req, 0);
        check("hold_drop", layer_hold, 0);
        check("no_to_pulse", timeout_pulse, 0);
        tick();
        check("hold_gap", layer_hold, 0);
    endtask

    initial begin
        int hw;
        int n;

        warm_resn        = 1'b1;
        layer_interruptn = '1;
        layer_enable     = '1;
        rd_done          = 1'b0;

        // ---- reset state ----
        #2 warm_resn = 1'b0;
        #1;
        layer_interruptn[1] = 1'b0;   // must not reach pending while in reset
        tick();
        tick();
        check("rst_hold", layer_hold, 0);
        check("rst_req", rd_req, 0);
        check("rst_layer", rd_layer, 0);
        check("rst_pending", pending, 0);
        check("rst_to_pulse", timeout_pulse, 0);
        check("rst_to_layer", timeout_layer, 0);
        layer_interruptn[1] = 1'b1;
        tick();
        warm_resn = 1'b1;
        tick();
        tick();

        // ---- single request, layer 5 ----
        layer_interruptn[5] = 1'b0;
        exp_q.push_back(5);
        tick();                                 // edge k
        check("pend_k", pending, 0);
        tick();                                 // edge k+1
        check("pend_k1", pending, 32'd1 << 5);
        grant_check(hw);
        check("int_to_hold", hw, 1);            // hold at k+2
        layer_interruptn[5] = 1'b1;
        finish_read(9);                         // done sampled 10 cycles after req

        // ---- round robin: 3, 7, 19 (pointer starts at 5) ----
        layer_interruptn[3]  = 1'b0;
        layer_interruptn[7]  = 1'b0;
        layer_interruptn[19] = 1'b0;
        exp_q.push_back(7);  exp_q.push_back(19); exp_q.push_back(3);
        exp_q.push_back(7);  exp_q.push_back(19); exp_q.push_back(3);
        exp_q.push_back(7);  exp_q.push_back(19);
        for (int i = 0; i < 7; i++) begin
            grant_check(hw);
            finish_read(0);
        end
        grant_check(hw);
        layer_interruptn = '1;
        finish_read(3);

        // ---- wrap-around: pointer 19, layers 0 and 19 pending ----
        layer_interruptn[0]  = 1'b0;
        layer_interruptn[19] = 1'b0;
        exp_q.push_back(0);
        exp_q.push_back(19);
        grant_check(hw);
        finish_read(0);
        grant_check(hw);
        layer_interruptn = '1;
        finish_read(3);

        // ---- wrap with mask: layer 0 disabled, layer 2 served ----
        layer_enable[0]     = 1'b0;
        layer_interruptn[0] = 1'b0;
        layer_interruptn[2] = 1'b0;
        exp_q.push_back(2);
        tick();
        tick();
        check("pend_masked", pending, 32'd1 << 2);
        grant_check(hw);
        layer_interruptn = '1;
        finish_read(3);
        layer_enable = '1;

        // ---- timeout on layer 11, then layer 13 served ----
        layer_interruptn[11] = 1'b0;
        layer_interruptn[13] = 1'b0;
        exp_q.push_back(11);
        exp_q.push_back(13);
        grant_check(hw);
        layer_interruptn[11] = 1'b1;
        n = 0;
        while (!timeout_pulse && n < 60) begin
            tick();
            n++;
        end
        check("to_latency", n, TO);
        check("to_req_drop", rd_req, 0);
        check("to_hold_drop", layer_hold, 0);
        check("to_layer", timeout_layer, 11);
        $display("[TB] timeout layer %0d after %0d cycles", timeout_layer, n);
        tick();
        check("to_one_cycle", timeout_pulse, 0);
        grant_check(hw);
        layer_interruptn[13] = 1'b1;
        finish_read(3);

        // ---- done in the watchdog terminal cycle ----
        layer_interruptn[8] = 1'b0;
        exp_q.push_back(8);
        grant_check(hw);
        layer_interruptn[8] = 1'b1;
        repeat (TO - 1) tick();
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        check("sim_no_pulse", timeout_pulse, 0);
        check("sim_req_drop", rd_req, 0);
        check("sim_hold_drop", layer_hold, 0);
        check("sim_to_layer_kept", timeout_layer, 11);
        tick();
        check("sim_no_late_pulse", timeout_pulse, 0);
        $display("[TB] done on terminal count: no timeout pulse");

        // ---- asynchronous reset during READ ----
        layer_interruptn[0] = 1'b0;
        layer_interruptn[9] = 1'b0;
        exp_q.push_back(9);
        grant_check(hw);
        tick();
        tick();
        warm_resn = 1'b0;
        #1;
        check("arst_hold", layer_hold, 0);
        check("arst_req", rd_req, 0);
        check("arst_layer", rd_layer, 0);
        check("arst_to_layer", timeout_layer, 0);
        check("arst_pending", pending, 0);
        $display("[TB] async reset during read");
        tick();
        tick();
        warm_resn = 1'b1;
        exp_q.push_back(0);
        exp_q.push_back(9);
        grant_check(hw);
        layer_interruptn[0] = 1'b1;
        finish_read(0);
        grant_check(hw);
        layer_interruptn = '1;
        finish_read(2);

        repeat (5) tick();
        check("idle_hold", layer_hold, 0);
        check("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
